// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the two-digit BCD display driver.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the top.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP0  = 2'd1,
    S_TENS  = 2'd2,
    S_GAP1  = 2'd3
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_E     = 7'h79;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment pattern.
// Values above 9 render as 'E'.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // pure lookup, invalid codes fall through to 'E'
  always_comb begin
    seg_o = SEG_E;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_seg_mux_driver.sv
// Two-digit multiplexed 7-seg driver with blanking gaps and per-frame snapshot.
// Optional: BCD_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_seg_mux_driver
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [CW-1:0] cnt_q, cnt_d;
  disp_state_e   state_q, state_d;
  logic [3:0]    snap_tens_q, snap_tens_d;
  logic [3:0]    snap_units_q, snap_units_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          fs_q, fs_d;

  logic       tick;
  logic       enter_units;
  logic [3:0] dec_digit;
  logic [6:0] dec_seg;
  logic [6:0] seg_on;
  logic [1:0] an_on;

  assign tick        = (cnt_q == LAST);
  assign enter_units = tick && (state_q == S_GAP1);

  // prescaler, slot sequencing and frame snapshot
  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    snap_tens_d  = snap_tens_q;
    snap_units_d = snap_units_q;
    if (tick) begin
      unique case (state_q)
        S_UNITS: state_d = S_GAP0;
        S_GAP0:  state_d = S_TENS;
        S_TENS:  state_d = S_GAP1;
        S_GAP1:  state_d = S_UNITS;
        default: state_d = S_GAP1;
      endcase
    end
    if (enter_units) begin
      snap_tens_d  = tens;
      snap_units_d = units;
    end
  end

  assign dec_digit = (state_d == S_TENS) ? snap_tens_d : snap_units_d;

  bcd_to_seg7 u_dec (
    .bcd_i (dec_digit),
    .seg_o (dec_seg)
  );

  // next registered outputs follow the next state, gaps stay dark
  always_comb begin
    seg_on = SEG_BLANK;
    an_on  = 2'b00;
    unique case (state_d)
      S_UNITS: begin
        seg_on = dec_seg;
        an_on  = 2'b01;
      end
      S_TENS: begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (snap_tens_d != 4'd0) begin
          seg_on = dec_seg;
          an_on  = 2'b10;
        end
`else
        seg_on = dec_seg;
        an_on  = 2'b10;
`endif
      end
      default: begin
        seg_on = SEG_BLANK;
        an_on  = 2'b00;
      end
    endcase
    seg_d = ACTIVE_LOW ? ~seg_on : seg_on;
    an_d  = ACTIVE_LOW ? ~an_on : an_on;
    fs_d  = enter_units;
  end

  // state and output registers, reset blanks the display at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      state_q      <= S_GAP1;
      snap_tens_q  <= 4'd0;
      snap_units_q <= 4'd0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      fs_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      snap_tens_q  <= snap_tens_d;
      snap_units_q <= snap_units_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
